instr_fetch_unit: RTL and testbench

//  Upstream fetch stage for the 4-bit HMMM-style core (10-bit instructions, 8-bit instruction addresses).

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instr_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: instruction/address widths,
// the FIFO entry layout and the fetch FSM state encoding.
package fetch_pkg;

  typedef logic [9:0] instr_t;
  typedef logic [7:0] iaddr_t;

  typedef struct packed {
    iaddr_t pc;
    instr_t instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // Sequential fetch address; wraps 8'hFF -> 8'h00 by width.
  function automatic iaddr_t next_pc(input iaddr_t pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries.
// DEPTH must be a power of two so the pointers wrap naturally.
// Clear empties the buffer and wins over a same-cycle push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push_s;
  logic          do_pop_s;

  // A push into a full buffer is only accepted when a pop frees the head slot.
  assign do_pop_s  = pop & (cnt_q != {CW{1'b0}});
  assign do_push_s = push & ((cnt_q != DEPTH_C) | do_pop_s);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_q  <= {PW{1'b0}};
      rd_q  <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_q <= wr_q + PW'(1);
      if (do_pop_s)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Entry storage; contents are meaningless while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (do_push_s && !clear && !reset) mem_q[wr_q] <= push_data;
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: sequential imem requests (one outstanding at most), buffered
// in fetch_fifo and handed to decode over valid/ready. A redirect flushes
// the buffer and restarts at the target, draining any in-flight request first.
// Optional: define FETCH_PERF_EN to add saturating stall/flush counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int           DEPTH    = 4,
  parameter logic [7:0]   RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [9:0] imem_rdata,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [9:0] instr_data,
  output logic [7:0] instr_pc,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic          req_q, req_d;
  iaddr_t        addr_q, addr_d;
  iaddr_t        target_q, target_d;

  logic          push_s;
  logic          pop_s;
  logic          clear_s;
  logic [CW-1:0] count_s;
  logic [CW-1:0] count_after_s;
  fetch_entry_t  push_data_s;
  fetch_entry_t  head_s;

  // Only a completion in RUN without a redirect is kept; everything else is stale.
  assign push_s        = (state_q == RUN) & req_q & imem_ack & ~redirect_valid;
  assign pop_s         = instr_valid & instr_ready & ~redirect_valid;
  assign clear_s       = redirect_valid;
  assign push_data_s   = '{pc: addr_q, instr: imem_rdata};
  // Occupancy after this edge; the next launch reserves one slot against it.
  assign count_after_s = count_s + CW'(push_s) - CW'(pop_s);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_s),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .count     (count_s),
    .head      (head_s)
  );

  // State, request and address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      target_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      target_q <= target_d;
    end
  end

  // Next-state: launch/hold decisions, redirect handling and drain of stale requests.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    target_d = target_q;
    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          target_d = redirect_pc;
          if (req_q && !imem_ack) begin
            // In-flight request cannot be retracted; wait it out.
            state_d = DRAIN;
            req_d   = 1'b1;
            addr_d  = addr_q;
          end else begin
            state_d = RUN;
            req_d   = 1'b1;
            addr_d  = redirect_pc;
          end
        end else begin
          state_d = RUN;
          if (req_q && imem_ack) begin
            addr_d = next_pc(addr_q);
          end else begin
            addr_d = addr_q;
          end
          req_d = (req_q & ~imem_ack) | (count_after_s < DEPTH_C);
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          target_d = redirect_pc;
        end else begin
          target_d = target_q;
        end
        if (imem_ack) begin
          state_d = RUN;
          req_d   = 1'b1;
          addr_d  = redirect_valid ? redirect_pc : target_q;
        end else begin
          state_d = DRAIN;
          req_d   = 1'b1;
          addr_d  = addr_q;
        end
      end
      default: begin
        state_d  = RUN;
        req_d    = 1'b0;
        addr_d   = RESET_PC;
        target_d = RESET_PC;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = (count_s != {CW{1'b0}});
  assign instr_data  = instr_valid ? head_s.instr : 10'd0;
  assign instr_pc    = instr_valid ? head_s.pc    : 8'd0;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  // Saturating counters for request stall cycles and redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (req_q && !imem_ack && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (redirect_valid && (flush_q != 16'hFFFF))     flush_q <= flush_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (DEPTH=4, RESET_PC=0).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_instr_fetch_unit;

  logic       clk;
  logic       reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [9:0] imem_rdata;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] instr_data;
  logic [7:0] instr_pc;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as seen by the bench.
  function automatic logic [9:0] mem_word(input logic [7:0] a);
    return {a[1:0], a} ^ 10'h2A5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 10'd0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Memory answers in the same cycle as the request.
  task automatic mem_respond();
    imem_ack   = imem_req;
    imem_rdata = mem_word(imem_addr);
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 10'd0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    tick(); tick();
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0h exp 0", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 8'h00) $display("FAIL reset_addr: got %0h exp 00", imem_addr); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %0h exp 0", instr_valid); else n_pass++;
    n_checks++; if (instr_data !== 10'd0) $display("FAIL reset_data: got %0h exp 0", instr_data); else n_pass++;
    n_checks++; if (instr_pc !== 8'h00) $display("FAIL reset_pc: got %0h exp 0", instr_pc); else n_pass++;
  endtask

  task automatic test_streaming();
    do_reset();
    instr_ready = 1'b1;
    tick();
    n_checks++; if (imem_req !== 1'b1) $display("FAIL stream_first_req: got %0h exp 1", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 8'h00) $display("FAIL stream_first_addr: got %0h exp 00", imem_addr); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL stream_early_valid: got %0h exp 0", instr_valid); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      mem_respond();
      tick();
      n_checks++; if (instr_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %0h exp 1", i, instr_valid); else n_pass++;
      n_checks++; if (instr_pc !== 8'(i)) $display("FAIL stream_pc[%0d]: got %0h exp %0h", i, instr_pc, 8'(i)); else n_pass++;
      n_checks++; if (instr_data !== mem_word(8'(i))) $display("FAIL stream_data[%0d]: got %0h exp %0h", i, instr_data, mem_word(8'(i))); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int acks;
    logic [7:0] exp_pc;
    bit seen_req;
    do_reset();
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      mem_respond();
      if (imem_ack) acks++;
      tick();
    end
    imem_ack = 1'b0;
    n_checks++; if (acks != 4) $display("FAIL bp_acks: got %0d exp 4", acks); else n_pass++;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL bp_req_idle: got %0h exp 0", imem_req); else n_pass++;
    n_checks++; if (instr_pc !== 8'h00 || instr_valid !== 1'b1) $display("FAIL bp_head: got v=%0h pc=%0h exp v=1 pc=00", instr_valid, instr_pc); else n_pass++;
    instr_ready = 1'b1;
    exp_pc = 8'h00;
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) begin
        n_checks++; if (instr_pc !== exp_pc || instr_data !== mem_word(exp_pc)) $display("FAIL bp_order: got pc=%0h d=%0h exp pc=%0h d=%0h", instr_pc, instr_data, exp_pc, mem_word(exp_pc)); else n_pass++;
        exp_pc = exp_pc + 8'd1;
      end
      if (imem_req && !seen_req) begin
        seen_req = 1'b1;
        n_checks++; if (imem_addr !== 8'h04) $display("FAIL bp_resume_addr: got %0h exp 04", imem_addr); else n_pass++;
      end
      mem_respond();
      tick();
    end
    n_checks++; if (exp_pc < 8'h07) $display("FAIL bp_progress: got %0h consumed exp at least 07", exp_pc); else n_pass++;
  endtask

  task automatic test_redirect_pending();
    do_reset();
    instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL rdp_hold1: got req=%0h addr=%0h exp req=1 addr=00", imem_req, imem_addr); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL rdp_valid1: got %0h exp 0", instr_valid); else n_pass++;
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL rdp_hold2: got req=%0h addr=%0h exp req=1 addr=00", imem_req, imem_addr); else n_pass++;
    imem_ack = 1'b1; imem_rdata = mem_word(8'h00);
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h40) $display("FAIL rdp_target: got req=%0h addr=%0h exp req=1 addr=40", imem_req, imem_addr); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL rdp_dropped: got %0h exp 0", instr_valid); else n_pass++;
    mem_respond();
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h40) $display("FAIL rdp_first: got v=%0h pc=%0h exp v=1 pc=40", instr_valid, instr_pc); else n_pass++;
    n_checks++; if (instr_data !== mem_word(8'h40)) $display("FAIL rdp_data: got %0h exp %0h", instr_data, mem_word(8'h40)); else n_pass++;
  endtask

  task automatic test_redirect_ack_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem_respond();
      tick();
    end
    n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 8'h03) $display("FAIL rap_setup: got v=%0h req=%0h addr=%0h exp v=1 req=1 addr=03", instr_valid, imem_req, imem_addr); else n_pass++;
    instr_ready = 1'b1;
    imem_ack = 1'b1; imem_rdata = mem_word(8'h03);
    redirect_valid = 1'b1; redirect_pc = 8'h80;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL rap_flush: got %0h exp 0", instr_valid); else n_pass++;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h80) $display("FAIL rap_target: got req=%0h addr=%0h exp req=1 addr=80", imem_req, imem_addr); else n_pass++;
    mem_respond();
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h80) $display("FAIL rap_first: got v=%0h pc=%0h exp v=1 pc=80", instr_valid, instr_pc); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_tab [4];
    exp_tab[0] = 8'hFE; exp_tab[1] = 8'hFF; exp_tab[2] = 8'h00; exp_tab[3] = 8'h01;
    do_reset();
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'hFE) $display("FAIL wrap_launch: got req=%0h addr=%0h exp req=1 addr=FE", imem_req, imem_addr); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      mem_respond();
      tick();
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_tab[i]) $display("FAIL wrap_pc[%0d]: got v=%0h pc=%0h exp v=1 pc=%0h", i, instr_valid, instr_pc, exp_tab[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr_ready = 1'b0;
    tick();
    imem_ack = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 8'h20;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL rm_pending: got req=%0h addr=%0h exp req=1 addr=00", imem_req, imem_addr); else n_pass++;
`ifdef FETCH_PERF_EN
    n_checks++; if (perf_stall_cnt !== 16'd2) $display("FAIL rm_stall_cnt: got %0d exp 2", perf_stall_cnt); else n_pass++;
    n_checks++; if (perf_flush_cnt !== 16'd1) $display("FAIL rm_flush_cnt: got %0d exp 1", perf_flush_cnt); else n_pass++;
`endif
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = mem_word(8'h00);
    tick();
    n_checks++; if (imem_req !== 1'b0) $display("FAIL rm_req: got %0h exp 0", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 8'h00) $display("FAIL rm_addr: got %0h exp 00", imem_addr); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0 || instr_data !== 10'd0 || instr_pc !== 8'h00) $display("FAIL rm_out: got v=%0h d=%0h pc=%0h exp all 0", instr_valid, instr_data, instr_pc); else n_pass++;
`ifdef FETCH_PERF_EN
    n_checks++; if (perf_stall_cnt !== 16'd0 || perf_flush_cnt !== 16'd0) $display("FAIL rm_perf_clr: got s=%0d f=%0d exp 0 0", perf_stall_cnt, perf_flush_cnt); else n_pass++;
`endif
    imem_ack = 1'b0;
    reset = 1'b0;
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00 || instr_valid !== 1'b0) $display("FAIL rm_restart: got req=%0h addr=%0h v=%0h exp 1 00 0", imem_req, imem_addr, instr_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_pending();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
